// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI master among three requesters,
// with a WAIT-state watchdog that completes a stuck transaction with a timeout.
module spi_arbiter #(
  parameter int TO_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  req_ss_0,
  input  logic [2:0]  req_ss_1,
  input  logic [2:0]  req_ss_2,
  input  logic [15:0] req_data_0,
  input  logic [15:0] req_data_1,
  input  logic [15:0] req_data_2,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [15:0] rd_data,
  output logic        timeout,
  output logic        wrt_SPI,
  output logic [2:0]  ss,
  output logic [15:0] SPI_data,
  input  logic        SPI_done,
  input  logic [15:0] SPI_rdata
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  localparam logic [12:0] WD_LAST = 13'(TO_CYCLES - 1);
  state_t      state, nxt;
  logic [12:0] wd;
  logic [1:0]  last_gnt, s0, s1, s2, win;
  logic        wd_hit, grant, finish;
  logic        wrt_d, timeout_d;
  logic [2:0]  done_d;
  // search order starts just after the previous winner and wraps 2 -> 0
  always_comb begin
    s0 = last_gnt == 2'd2 ? 2'd0 : last_gnt + 2'd1;
    s1 = s0 == 2'd2 ? 2'd0 : s0 + 2'd1;
    s2 = s1 == 2'd2 ? 2'd0 : s1 + 2'd1;
    win = req[s0] ? s0 : req[s1] ? s1 : s2;
  end
  assign wd_hit = wd == WD_LAST;
  assign grant  = state == IDLE && |req;
  assign finish = state == WAIT && (SPI_done || wd_hit);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = grant ? LAUNCH : IDLE;
      LAUNCH:  nxt = WAIT;
      WAIT:    nxt = finish ? DONE : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    wrt_d     = nxt == LAUNCH;
    done_d    = nxt == DONE ? gnt : 3'b000;
    timeout_d = finish && !SPI_done;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= 3'b000;
      done     <= 3'b000;
      timeout  <= 1'b0;
      wrt_SPI  <= 1'b0;
      ss       <= 3'b000;
      SPI_data <= 16'h0000;
      rd_data  <= 16'h0000;
      wd       <= 13'd0;
      last_gnt <= 2'd2;
    end else begin
      wrt_SPI <= wrt_d;
      done    <= done_d;
      timeout <= timeout_d;
      wd      <= state == WAIT ? wd + 13'd1 : 13'd0;
      if (grant) begin
        gnt      <= 3'(3'b001 << win);
        last_gnt <= win;
        ss       <= win == 2'd0 ? req_ss_0 : win == 2'd1 ? req_ss_1 : req_ss_2;
        SPI_data <= win == 2'd0 ? req_data_0 : win == 2'd1 ? req_data_1 : req_data_2;
      end else if (state == DONE) begin
        gnt <= 3'b000;
      end
      if (finish) rd_data <= SPI_done ? SPI_rdata : 16'h0000;
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed and randomized checks of spi_arbiter against a
// transaction-level model (owner, cycles since grant, WAIT cycles elapsed).
module tb_spi_arbiter;
  localparam int TO = 16;
  logic        clk, rst_n;
  logic [2:0]  req, req_ss_0, req_ss_1, req_ss_2, gnt, done, ss;
  logic [15:0] req_data_0, req_data_1, req_data_2, rd_data, SPI_data, SPI_rdata;
  logic        timeout, wrt_SPI, SPI_done;
  int n_err, n_chk;
  spi_arbiter #(.TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_ss_0(req_ss_0), .req_ss_1(req_ss_1), .req_ss_2(req_ss_2),
    .req_data_0(req_data_0), .req_data_1(req_data_1), .req_data_2(req_data_2),
    .gnt(gnt), .done(done), .rd_data(rd_data), .timeout(timeout),
    .wrt_SPI(wrt_SPI), .ss(ss), .SPI_data(SPI_data),
    .SPI_done(SPI_done), .SPI_rdata(SPI_rdata)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // model: owner of the master (-1 none), cycles since grant, WAIT cycles elapsed
  int          own, age, waited, m_last;
  bit          fin, e_to, chk_en;
  logic [2:0]  e_ss;
  logic [15:0] e_data, e_rd;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    own = -1; age = 0; waited = 0; fin = 0; e_to = 0; m_last = 2;
    e_ss = 0; e_data = 0; e_rd = 0;
  endtask
  task automatic model_step();
    int j;
    if (!rst_n) return;
    if (own < 0) begin
      if (req != 0) begin
        for (int i = 1; i <= 3; i++) begin
          j = (m_last + i) % 3;
          if (req[j]) begin own = j; break; end
        end
        m_last = own; age = 1; waited = 0; fin = 0;
        e_ss   = own == 0 ? req_ss_0 : own == 1 ? req_ss_1 : req_ss_2;
        e_data = own == 0 ? req_data_0 : own == 1 ? req_data_1 : req_data_2;
      end
    end else if (fin) begin
      own = -1; fin = 0;
    end else if (age == 1) begin
      age = 2;
    end else begin
      waited++;
      if (SPI_done) begin fin = 1; e_rd = SPI_rdata; e_to = 0; end
      else if (waited == TO) begin fin = 1; e_rd = 0; e_to = 1; end
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    check("gnt", gnt, own >= 0 ? 3'(1 << own) : 3'b000);
    check("wrt_SPI", wrt_SPI, own >= 0 && age == 1);
    check("done", done, fin ? 3'(1 << own) : 3'b000);
    check("timeout", timeout, fin && e_to);
    check("ss", ss, e_ss);
    check("SPI_data", SPI_data, e_data);
    check("rd_data", rd_data, e_rd);
    check("gnt_onehot", $countones(gnt) <= 1, 1);
  end
  // SPI master stand-in: answers d_rsp cycles after a launch (0 = never)
  int pend, d_rsp;
  bit rnd, rsp;
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    rsp = 0;
    if (pend > 0) begin pend--; rsp = pend == 0; end
    if (wrt_SPI) pend = rnd ? int'($urandom_range(20, 1)) : d_rsp;
    SPI_done = rsp || (rnd && $urandom_range(15, 0) == 0);
    if (rnd) SPI_rdata = 16'($urandom);
  endtask
  task automatic do_reset();
    rst_n = 0; model_reset(); pend = 0; SPI_done = 0; req = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask
  logic [2:0]  g, d_val, w_ss;
  logic [15:0] w_data, d_rd;
  int wc, dc, lat, t0;
  bit d_to;
  task automatic watch(int n);
    g = 0; wc = 0; dc = 0; d_val = 0; d_to = 0; d_rd = 0; lat = -1; t0 = 0; w_ss = 0; w_data = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (gnt != 0 && g == 0) begin
        g = gnt;
        req_ss_0 = ~req_ss_0; req_ss_1 = ~req_ss_1; req_ss_2 = ~req_ss_2;
        req_data_0 = ~req_data_0; req_data_1 = ~req_data_1; req_data_2 = ~req_data_2;
      end
      if (wrt_SPI) begin wc++; w_ss = ss; w_data = SPI_data; t0 = i; end
      if (done != 0) begin
        dc++; d_val = done; d_to = timeout; d_rd = rd_data; lat = i - t0; req = 0;
        break;
      end
    end
  endtask
  int order[$];
  logic [2:0] prev;
  bit found;
  initial begin
    n_err = 0; n_chk = 0; chk_en = 0; rnd = 0; pend = 0; d_rsp = 0;
    rst_n = 1; req = 0; SPI_done = 0; SPI_rdata = 0;
    req_ss_0 = 0; req_ss_1 = 0; req_ss_2 = 0; req_data_0 = 0; req_data_1 = 0; req_data_2 = 0;
    model_reset();
    #1;
    do_reset();
    chk_en = 1;
    check("rst_gnt", gnt, 3'b000);
    check("rst_ss", ss, 3'b000);
    check("rst_data", SPI_data, 16'h0000);
    check("rst_rd", rd_data, 16'h0000);
    // single requester 1
    req = 3'b010; req_ss_1 = 3'b100; req_data_1 = 16'h0A55; d_rsp = 5; SPI_rdata = 16'h00C3;
    watch(30);
    check("r31_gnt", g, 3'b010);
    check("r31_wrt_count", wc, 1);
    check("r31_ss", w_ss, 3'b100);
    check("r31_data", w_data, 16'h0A55);
    check("r31_done_count", dc, 1);
    check("r31_done", d_val, 3'b010);
    check("r31_rd", d_rd, 16'h00C3);
    check("r31_latency", lat, 6);
    cyc();
    check("r31_ss_hold", ss, 3'b100);
    check("r31_data_hold", SPI_data, 16'h0A55);
    // all three requesting: strict rotation
    do_reset();
    req = 3'b111; d_rsp = 2; SPI_rdata = 16'h1111; prev = 0;
    order.delete();
    for (int i = 0; i < 60 && order.size() < 6; i++) begin
      cyc();
      if (gnt != 0 && prev == 0) order.push_back(gnt[0] ? 0 : gnt[1] ? 1 : 2);
      prev = gnt;
    end
    check("r32_count", order.size(), 6);
    for (int k = 0; k < order.size(); k++) check("r32_order", order[k], k % 3);
    req = 0;
    for (int i = 0; i < 8; i++) cyc();
    // watchdog expiry, then SPI_done on the last WAIT cycle
    do_reset();
    req = 3'b100; req_ss_2 = 3'b001; req_data_2 = 16'h7E7E; d_rsp = 0; SPI_rdata = 16'hBEEF;
    watch(40);
    check("r33_done", d_val, 3'b100);
    check("r33_timeout", d_to, 1);
    check("r33_rd", d_rd, 16'h0000);
    check("r33_latency", lat, 17);
    req = 3'b100; d_rsp = 16;
    watch(40);
    check("r34_done", d_val, 3'b100);
    check("r34_timeout", d_to, 0);
    check("r34_rd", d_rd, 16'hBEEF);
    check("r34_latency", lat, 17);
    // reset during WAIT with SPI_done arriving after release
    do_reset();
    req = 3'b001; req_ss_0 = 3'b010; req_data_0 = 16'h1234; d_rsp = 5; found = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (wrt_SPI) begin found = 1; break; end
    end
    check("r35_launch", found, 1);
    cyc(); cyc();
    rst_n = 0; model_reset(); req = 0;
    cyc(); cyc();
    rst_n = 1;
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (done != 0 || timeout || wrt_SPI || gnt != 0) dc++;
    end
    check("r35_quiet", dc, 0);
    check("r35_ss", ss, 3'b000);
    check("r35_data", SPI_data, 16'h0000);
    check("r35_rd", rd_data, 16'h0000);
    req = 3'b111; d_rsp = 2;
    watch(20);
    check("r35_first", g, 3'b001);
    check("r35_done_count", dc, 1);
    // randomized traffic with spurious SPI_done pulses and one mid-run reset
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin rnd = 0; do_reset(); rnd = 1; end
      req = 3'($urandom);
      req_ss_0 = 3'($urandom); req_ss_1 = 3'($urandom); req_ss_2 = 3'($urandom);
      req_data_0 = 16'($urandom); req_data_1 = 16'($urandom); req_data_2 = 16'($urandom);
      cyc();
    end
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
